// File: rtl/fixed_predictor_encoder_pkg.sv
// rtl/fixed_predictor_encoder_pkg.sv - shared types and width helpers for the fixed predictor encoder
//
// Purpose: state encoding, order-field width and the derived-width functions
//          used by the encoder top level and the difference cascade.
// Ports:   none (package).

package fixed_predictor_encoder_pkg;

  localparam int ORD_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ANALYSE = 3'd1,
    ST_SELECT  = 3'd2,
    ST_ENCODE  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Residual width: each difference stage can grow the range by one bit.
  function automatic int res_width(input int sample_w, input int max_order);
    return sample_w + max_order;
  endfunction

  // Sum width: up to 2^addr_w residual magnitudes are accumulated.
  function automatic int sum_width(input int res_w, input int addr_w);
    return res_w + addr_w;
  endfunction

endpackage

// File: rtl/fixed_diff_cascade.sv
// rtl/fixed_diff_cascade.sv - difference cascade producing fixed-predictor residuals of every order
//
// Purpose: d0 = x, dk = d(k-1) - previous d(k-1). History registers hold the
//          previous value of each stage; outputs are combinational from the
//          current input sample and the history.
// Ports:
//   i_clk      clock
//   i_reset    synchronous active-high reset
//   i_enable   clock enable; low freezes the history
//   i_clear    zero the history (start of a pass)
//   i_advance  shift the current differences into the history
//   i_sample   current signed sample
//   o_diff     d0..dMAX_ORDER for the current sample

module fixed_diff_cascade
  import fixed_predictor_encoder_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int MAX_ORDER = 4,
  localparam int RES_W    = res_width(SAMPLE_W, MAX_ORDER)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_clear,
  input  logic                       i_advance,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic signed [RES_W-1:0]    o_diff [0:MAX_ORDER]
);

  logic signed [RES_W-1:0] r_hist [0:MAX_ORDER-1];

  // A running value keeps each stage's input out of the output array itself.
  always_comb begin
    logic signed [RES_W-1:0] w_acc;
    w_acc     = {{MAX_ORDER{i_sample[SAMPLE_W-1]}}, i_sample};
    o_diff[0] = w_acc;
    for (int k = 1; k <= MAX_ORDER; k++) begin
      w_acc     = w_acc - r_hist[k-1];
      o_diff[k] = w_acc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < MAX_ORDER; k++) r_hist[k] <= '0;
    end else if (i_enable) begin
      if (i_clear) begin
        for (int k = 0; k < MAX_ORDER; k++) r_hist[k] <= '0;
      end else if (i_advance) begin
        for (int k = 0; k < MAX_ORDER; k++) r_hist[k] <= o_diff[k];
      end
    end
  end

endmodule

// File: rtl/fixed_predictor_encoder.sv
// rtl/fixed_predictor_encoder.sv - selects the cheapest FLAC fixed predictor and writes residuals
//
// Purpose: reads N samples, accumulates |dk| for orders 0..MAX_ORDER, picks
//          the cheapest eligible order (ties to the lowest), then re-reads the
//          block and writes warm-up samples followed by residuals.
// Optional feature macro: FIXED_PREDICTOR_FORCE_ORDER_EN (adds iForceValid /
//          iForceOrder to skip analysis and encode with a given order).
// Ports:
//   iClock, iReset              clock, synchronous active-high reset
//   iEnable                     clock enable
//   iStart, iBlockSize          start pulse and sample count N
//   oRamReadAddr, iRamReadData  sample RAM, 1-cycle read latency
//   oRamWriteAddr/Data/Enable   residual RAM write port
//   oBestOrder, oBestSum        selected order and its absolute-residual sum
//   oBusy, oDone                activity flag and completion pulse

module fixed_predictor_encoder
  import fixed_predictor_encoder_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_ORDER = 4,
  localparam int RES_W    = res_width(SAMPLE_W, MAX_ORDER),
  localparam int SUM_W    = sum_width(RES_W, ADDR_W)
) (
  input  logic                       iClock,
  input  logic                       iReset,
`ifdef FIXED_PREDICTOR_FORCE_ORDER_EN
  input  logic                       iForceValid,
  input  logic [ORD_W-1:0]           iForceOrder,
`endif
  input  logic                       iEnable,
  input  logic                       iStart,
  input  logic [ADDR_W:0]            iBlockSize,
  output logic [ADDR_W-1:0]          oRamReadAddr,
  input  logic signed [SAMPLE_W-1:0] iRamReadData,
  output logic [ADDR_W-1:0]          oRamWriteAddr,
  output logic signed [RES_W-1:0]    oRamWriteData,
  output logic                       oRamWriteEnable,
  output logic [ORD_W-1:0]           oBestOrder,
  output logic [SUM_W-1:0]           oBestSum,
  output logic                       oBusy,
  output logic                       oDone
);

  state_t                  r_state;
  logic [ADDR_W:0]         r_n;
  logic [ADDR_W:0]         r_cnt;
  logic [ORD_W-1:0]        r_sel;
  logic [ORD_W-1:0]        r_best_ord;
  logic [SUM_W-1:0]        r_best_sum;
  logic [SUM_W-1:0]        r_sum [0:MAX_ORDER];

  logic signed [RES_W-1:0] w_diff [0:MAX_ORDER];
  logic                    w_start;
  logic                    w_valid;
  logic [ADDR_W:0]         w_idx;
  logic                    w_clear;
  logic                    w_advance;
  logic                    w_wr;
  logic                    w_sel_ok;

  function automatic logic [SUM_W-1:0] abs_ext(input logic signed [RES_W-1:0] v);
    logic [RES_W-1:0] m;
    m = v[RES_W-1] ? RES_W'(-v) : RES_W'(v);
    return SUM_W'(m);
  endfunction

  // r_cnt is the pass cycle index: address r_cnt is presented, and the data
  // returning this cycle belongs to sample r_cnt-1.
  assign w_start   = (r_state == ST_IDLE) && iStart;
  assign w_valid   = (r_cnt != '0);
  assign w_idx     = r_cnt - 1'b1;
  assign w_clear   = w_start || ((r_state == ST_SELECT) && (r_sel == ORD_W'(MAX_ORDER)));
  assign w_advance = ((r_state == ST_ANALYSE) || (r_state == ST_ENCODE)) && w_valid;
  assign w_wr      = (r_state == ST_ENCODE) && w_valid;
  // Order 0 always seeds the best; later orders need k < N and a strictly smaller sum.
  assign w_sel_ok  = ((ADDR_W+1)'(r_sel) < r_n) &&
                     ((r_sel == '0) || (r_sum[r_sel] < r_best_sum));

`ifdef FIXED_PREDICTOR_FORCE_ORDER_EN
  logic [ADDR_W:0]  w_force_lim;
  logic [ORD_W-1:0] w_force_ord;
  always_comb begin
    w_force_lim = (iBlockSize > (ADDR_W+1)'(MAX_ORDER)) ? (ADDR_W+1)'(MAX_ORDER)
                                                         : iBlockSize - 1'b1;
    w_force_ord = ((ADDR_W+1)'(iForceOrder) > w_force_lim) ? ORD_W'(w_force_lim)
                                                            : iForceOrder;
  end
`endif

  fixed_diff_cascade #(
    .SAMPLE_W  (SAMPLE_W),
    .MAX_ORDER (MAX_ORDER)
  ) u_cascade (
    .i_clk     (iClock),
    .i_reset   (iReset),
    .i_enable  (iEnable),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .i_sample  (iRamReadData),
    .o_diff    (w_diff)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_best_ord <= '0;
      r_best_sum <= '0;
      for (int k = 0; k <= MAX_ORDER; k++) r_sum[k] <= '0;
    end else if (iEnable) begin
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_n        <= iBlockSize;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_best_ord <= '0;
            r_best_sum <= '0;
            for (int k = 0; k <= MAX_ORDER; k++) r_sum[k] <= '0;
`ifdef FIXED_PREDICTOR_FORCE_ORDER_EN
            if (iForceValid) begin
              r_best_ord <= w_force_ord;
              r_state    <= (iBlockSize == '0) ? ST_DONE : ST_ENCODE;
            end else
`endif
            r_state <= (iBlockSize == '0) ? ST_DONE : ST_ANALYSE;
          end
        end

        ST_ANALYSE: begin
          for (int k = 0; k <= MAX_ORDER; k++) begin
            if (w_valid && (w_idx >= (ADDR_W+1)'(k)))
              r_sum[k] <= r_sum[k] + abs_ext(w_diff[k]);
          end
          if (r_cnt == r_n) begin
            r_sel   <= '0;
            r_state <= ST_SELECT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_SELECT: begin
          if (w_sel_ok) begin
            r_best_ord <= r_sel;
            r_best_sum <= r_sum[r_sel];
          end
          if (r_sel == ORD_W'(MAX_ORDER)) begin
            r_cnt   <= '0;
            r_state <= ST_ENCODE;
          end else begin
            r_sel <= r_sel + 1'b1;
          end
        end

        ST_ENCODE: begin
          if (r_cnt == r_n) r_state <= ST_DONE;
          else              r_cnt   <= r_cnt + 1'b1;
        end

        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oRamReadAddr    = r_cnt[ADDR_W-1:0];
  assign oRamWriteEnable = w_wr && iEnable;
  assign oRamWriteAddr   = w_wr ? w_idx[ADDR_W-1:0] : '0;
  // Warm-up samples go out verbatim (d0 is the sign-extended sample).
  assign oRamWriteData   = !w_wr ? '0 :
                           (w_idx < (ADDR_W+1)'(r_best_ord)) ? w_diff[0] : w_diff[r_best_ord];
  assign oBestOrder      = r_best_ord;
  assign oBestSum        = r_best_sum;
  assign oBusy           = (r_state != ST_IDLE);
  assign oDone           = (r_state == ST_DONE);

endmodule

// File: tb/tb_fixed_predictor_encoder.sv
// tb/tb_fixed_predictor_encoder.sv - directed self-checking bench for fixed_predictor_encoder

module tb_fixed_predictor_encoder;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iEnable;
  logic               iStart;
  logic [12:0]        iBlockSize;
  logic [11:0]        oRamReadAddr;
  logic signed [15:0] iRamReadData;
  logic [11:0]        oRamWriteAddr;
  logic signed [19:0] oRamWriteData;
  logic               oRamWriteEnable;
  logic [2:0]         oBestOrder;
  logic [31:0]        oBestSum;
  logic               oBusy;
  logic               oDone;

  logic signed [15:0] smem [4096];
  logic [19:0]        wmem [4096];
  int                 wr_count;
  int                 order_err;
  int                 done_count;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  always #5 iClock = ~iClock;

  fixed_predictor_encoder #(
    .SAMPLE_W  (16),
    .ADDR_W    (12),
    .MAX_ORDER (4)
  ) dut (
    .iClock          (iClock),
    .iReset          (iReset),
`ifdef FIXED_PREDICTOR_FORCE_ORDER_EN
    .iForceValid     (1'b0),
    .iForceOrder     (3'd0),
`endif
    .iEnable         (iEnable),
    .iStart          (iStart),
    .iBlockSize      (iBlockSize),
    .oRamReadAddr    (oRamReadAddr),
    .iRamReadData    (iRamReadData),
    .oRamWriteAddr   (oRamWriteAddr),
    .oRamWriteData   (oRamWriteData),
    .oRamWriteEnable (oRamWriteEnable),
    .oBestOrder      (oBestOrder),
    .oBestSum        (oBestSum),
    .oBusy           (oBusy),
    .oDone           (oDone)
  );

  // Clock-enabled sample RAM and residual RAM recorder.
  always @(posedge iClock) begin
    if (iEnable) iRamReadData <= smem[oRamReadAddr];
    if (iStart && iEnable && !oBusy && !iReset) begin
      wr_count   <= 0;
      order_err  <= 0;
      done_count <= 0;
      for (int i = 0; i < 4096; i++) wmem[i] <= 'x;
    end else begin
      if (oRamWriteEnable) begin
        if (oRamWriteAddr !== wr_count[11:0]) order_err <= order_err + 1;
        wmem[oRamWriteAddr] <= oRamWriteData;
        wr_count <= wr_count + 1;
      end
      if (oDone && iEnable) done_count <= done_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_block(input string tag, input int n, input bit rnd_en, output int cyc);
    @(negedge iClock);
    iEnable    = 1'b1;
    iBlockSize = 13'(n);
    iStart     = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    cyc    = 1;
    while (oDone !== 1'b1 && cyc < 60000) begin
      if (rnd_en) iEnable = ($urandom_range(0, 3) != 0);
      @(negedge iClock);
      cyc++;
    end
    chk({tag, "_done"}, oDone, 1);
    iEnable = 1'b1;
    @(negedge iClock);
    chk({tag, "_pulse"}, oDone, 0);
  endtask

  function automatic longint resid(input int k, input int n);
    longint a0, a1, a2, a3, a4;
    a0 = longint'(smem[n]);
    a1 = (n >= 1) ? longint'(smem[n-1]) : 0;
    a2 = (n >= 2) ? longint'(smem[n-2]) : 0;
    a3 = (n >= 3) ? longint'(smem[n-3]) : 0;
    a4 = (n >= 4) ? longint'(smem[n-4]) : 0;
    case (k)
      0:       return a0;
      1:       return a0 - a1;
      2:       return a0 - 2*a1 + a2;
      3:       return a0 - 3*a1 + 3*a2 - a3;
      default: return a0 - 4*a1 + 6*a2 - 4*a3 + a4;
    endcase
  endfunction

  initial begin
    int           cyc;
    int           v;
    int           bad;
    int           m_ord;
    longint       m_sum;
    longint       sums [5];
    longint       r;
    logic [19:0]  e;
    logic [19:0]  exp8 [8];

    iReset = 1'b1; iEnable = 1'b1; iStart = 1'b0; iBlockSize = '0;
    repeat (3) @(negedge iClock);
    chk("rst_busy",   oBusy, 0);
    chk("rst_done",   oDone, 0);
    chk("rst_we",     oRamWriteEnable, 0);
    chk("rst_raddr",  oRamReadAddr, 0);
    chk("rst_waddr",  oRamWriteAddr, 0);
    chk("rst_wdata",  oRamWriteData, 0);
    chk("rst_order",  oBestOrder, 0);
    chk("rst_sum",    oBestSum, 0);
    iReset = 1'b0;

    // Constant 100: sums [800,0,0,0,0] -> order 1
    for (int i = 0; i < 8; i++) smem[i] = 16'sd100;
    run_block("const", 8, 1'b0, cyc);
    chk("const_cyc", cyc, 24);
    chk("const_ord", oBestOrder, 1);
    chk("const_sum", oBestSum, 0);
    chk("const_nwr", wr_count, 8);
    chk("const_seq", order_err, 0);
    chk("const_ndone", done_count, 1);
    exp8 = '{20'd100, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0};
    for (int i = 0; i < 8; i++) chk($sformatf("const_wr%0d", i), wmem[i], exp8[i]);

    // Ramp: order 1 sum 7, order 2 sum 0 -> order 2
    for (int i = 0; i < 8; i++) smem[i] = 16'(i);
    run_block("ramp", 8, 1'b0, cyc);
    chk("ramp_cyc", cyc, 24);
    chk("ramp_ord", oBestOrder, 2);
    chk("ramp_sum", oBestSum, 0);
    chk("ramp_nwr", wr_count, 8);
    exp8 = '{20'd0, 20'd1, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0};
    for (int i = 0; i < 8; i++) chk($sformatf("ramp_wr%0d", i), wmem[i], exp8[i]);

    // N=1: only order 0 eligible
    smem[0] = -16'sd5;
    run_block("n1", 1, 1'b0, cyc);
    chk("n1_cyc", cyc, 10);
    chk("n1_ord", oBestOrder, 0);
    chk("n1_sum", oBestSum, 5);
    chk("n1_nwr", wr_count, 1);
    chk("n1_wr0", wmem[0], 20'hFFFFB);

    // N=2 [3,7]: order 1 sum 4 wins; order 2 (sum 0) is ineligible
    smem[0] = 16'sd3; smem[1] = 16'sd7;
    run_block("n2", 2, 1'b0, cyc);
    chk("n2_cyc", cyc, 12);
    chk("n2_ord", oBestOrder, 1);
    chk("n2_sum", oBestSum, 4);
    chk("n2_wr0", wmem[0], 3);
    chk("n2_wr1", wmem[1], 4);

    // N=0: straight to DONE, no writes
    run_block("n0", 0, 1'b0, cyc);
    chk("n0_cyc", cyc, 1);
    chk("n0_nwr", wr_count, 0);
    chk("n0_ndone", done_count, 1);
    chk("n0_sum", oBestSum, 0);

    // Random walk, full 4096 block, iEnable toggled
    v = 0;
    for (int i = 0; i < 4096; i++) begin
      v = v + int'($urandom_range(0, 2000)) - 1000;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      smem[i] = 16'(v);
    end
    for (int k = 0; k < 5; k++) begin
      sums[k] = 0;
      for (int n = k; n < 4096; n++) begin
        r = resid(k, n);
        sums[k] += (r < 0) ? -r : r;
      end
    end
    m_ord = 0; m_sum = sums[0];
    for (int k = 1; k < 5; k++) if (sums[k] < m_sum) begin m_ord = k; m_sum = sums[k]; end
    run_block("rand", 4096, 1'b1, cyc);
    chk("rand_ord", oBestOrder, 64'(m_ord));
    chk("rand_sum", oBestSum, 64'(m_sum));
    chk("rand_nwr", wr_count, 4096);
    chk("rand_seq", order_err, 0);
    bad = 0;
    for (int n = 0; n < 4096; n++) begin
      e = (n < m_ord) ? 20'(longint'(smem[n])) : 20'(resid(m_ord, n));
      if (wmem[n] !== e) bad++;
    end
    chk("rand_wr", bad, 0);

    // Reset during the 10th ENCODE write
    for (int i = 0; i < 64; i++) smem[i] = 16'(i);
    @(negedge iClock);
    iBlockSize = 13'd64; iStart = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    cyc = 0;
    while (!(oRamWriteEnable === 1'b1 && oRamWriteAddr === 12'd9) && cyc < 500) begin
      @(negedge iClock);
      cyc++;
    end
    chk("mid_reach", oRamWriteAddr, 9);
    iReset = 1'b1;
    @(negedge iClock);
    chk("mid_busy",  oBusy, 0);
    chk("mid_we",    oRamWriteEnable, 0);
    chk("mid_raddr", oRamReadAddr, 0);
    chk("mid_wdata", oRamWriteData, 0);
    chk("mid_order", oBestOrder, 0);
    chk("mid_sum",   oBestSum, 0);
    iReset = 1'b0;
    repeat (20) @(negedge iClock);
    chk("mid_nwr",   wr_count, 10);
    chk("mid_ndone", done_count, 0);

    // Recovery: ramp N=8 completes normally
    run_block("rec", 8, 1'b0, cyc);
    chk("rec_cyc", cyc, 24);
    chk("rec_ord", oBestOrder, 2);
    chk("rec_nwr", wr_count, 8);
    chk("rec_wr1", wmem[1], 1);
    chk("rec_wr7", wmem[7], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
